d_ff_pipe_stage: RTL and testbench

//  Parametrised successor to the single-bit D flip-flop cells. A WIDTH-bit, DEPTH-stage register

---
 rtl/d_ff_pipe_stage.sv | 125 ++++++++++++
 tb/tb_d_ff_pipe_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/d_ff_pipe_stage.sv
// d_ff_pipe_stage: WIDTH-bit, DEPTH-stage register pipeline with valid/ready
// flow control. Empty stages always pull from upstream, so bubbles collapse
// while the output is stalled. sync_reset flushes the valid bits only.
// async_reset clears the valid bits at once. It also loads RESET_VALUE into
// the data registers when RESET_DATA is set.
module d_ff_pipe_stage #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter bit               RESET_DATA  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       async_reset,
  input  logic                       sync_reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_value,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_value,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [DEPTH-1:0] next_v;
  logic [DEPTH-1:0] load;
  logic [CW-1:0]    next_count;

  // A stage may advance if it or any stage downstream of it has room.
  // The last stage also has room when the consumer takes its word.
  always_comb begin
    logic room;
    adv  = '0;
    room = i_ready;
    for (int k = DEPTH-1; k >= 0; k--) begin
      room   = room | ~v[k];
      adv[k] = room;
    end
  end

  // Each stage is fed by the stage before it; stage 0 is fed by the input port.
  always_comb begin
    src_valid[0] = i_valid;
    src_data[0]  = i_value;
    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k] = v[k-1];
      src_data[k]  = d[k-1];
    end
  end

  // Next valid bits, data load enables and the occupancy of the next state.
  // Data loads only when a real word arrives, which keeps idle toggling low.
  always_comb begin
    next_v     = v;
    load       = '0;
    next_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (adv[k]) begin
        next_v[k] = src_valid[k];
        load[k]   = src_valid[k];
      end
    end
    if (sync_reset) begin
      next_v = '0;
      load   = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      next_count = next_count + CW'(next_v[k]);
    end
  end

  // Valid bits and the occupancy count share one register update.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      v       <= '0;
      o_count <= '0;
    end else begin
      v       <= next_v;
      o_count <= next_count;
    end
  end

  generate
    if (RESET_DATA) begin : g_data_rst
      // Data registers with reset to RESET_VALUE.
      always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
          for (int k = 0; k < DEPTH; k++) begin
            d[k] <= RESET_VALUE;
          end
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            if (load[k]) begin
              d[k] <= src_data[k];
            end
          end
        end
      end
    end else begin : g_data_norst
      // Data registers without reset; they keep their contents across resets.
      always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (load[k]) begin
            d[k] <= src_data[k];
          end
        end
      end
    end
  endgenerate

  // Handshake outputs. A flush cycle neither accepts nor presents a word.
  always_comb begin
    o_ready = adv[0] & ~sync_reset;
    o_valid = v[DEPTH-1] & ~sync_reset;
    o_value = d[DEPTH-1];
  end

endmodule

// File: tb/tb_d_ff_pipe_stage.sv
// Testbench for d_ff_pipe_stage. Two builds share one stimulus stream:
// DEPTH=4 with data reset, and DEPTH=1 without data reset.
// Each build is compared against its own occupancy/shift reference model.
module tb_d_ff_pipe_stage;

  logic       clk = 1'b0;
  logic       async_reset;
  logic       sync_reset;
  logic       i_valid;
  logic [7:0] i_value;
  logic       i_ready;

  logic       o_ready4, o_valid4;
  logic [7:0] o_value4;
  logic [2:0] o_count4;
  logic       o_ready1, o_valid1;
  logic [7:0] o_value1;
  logic [0:0] o_count1;

  int num_checks = 0;
  int num_errors = 0;

  // Reference state: per build, per stage occupancy, data, and whether data is known
  bit         mv [2][4];
  logic [7:0] md [2][4];
  bit         mk [2][4];

  always #5 clk = ~clk;

  d_ff_pipe_stage #(.WIDTH(8), .DEPTH(4), .RESET_DATA(1'b1), .RESET_VALUE(8'h00)) dut4 (
    .clk(clk), .async_reset(async_reset), .sync_reset(sync_reset),
    .i_valid(i_valid), .o_ready(o_ready4), .i_value(i_value),
    .o_valid(o_valid4), .i_ready(i_ready), .o_value(o_value4), .o_count(o_count4)
  );

  d_ff_pipe_stage #(.WIDTH(8), .DEPTH(1), .RESET_DATA(1'b0), .RESET_VALUE(8'h00)) dut1 (
    .clk(clk), .async_reset(async_reset), .sync_reset(sync_reset),
    .i_valid(i_valid), .o_ready(o_ready1), .i_value(i_value),
    .o_valid(o_valid1), .i_ready(i_ready), .o_value(o_value1), .o_count(o_count1)
  );

  function automatic int dep(int m);
    return (m == 0) ? 4 : 1;
  endfunction

  // Model reset: everything empties; only the data-reset build knows its data.
  function automatic void modelReset(int m);
    for (int k = 0; k < 4; k++) begin
      mv[m][k] = 1'b0;
      if (m == 0) begin
        md[m][k] = 8'h00;
        mk[m][k] = 1'b1;
      end
    end
  endfunction

  // One clock in the model: locate the most downstream free slot.
  // A word leaving at the output also frees a slot.
  // Everything upstream of that slot moves one place forward, and the input fills stage 0.
  function automatic void modelStep(int m);
    int  d = dep(m);
    int  hole = -1;
    bit  found = 1'b0;
    if (sync_reset) begin
      for (int k = 0; k < d; k++) mv[m][k] = 1'b0;
      return;
    end
    if (i_ready) begin
      hole = d - 1;
    end else begin
      for (int k = d - 1; k >= 0; k--) begin
        if (!found && !mv[m][k]) begin
          hole  = k;
          found = 1'b1;
        end
      end
    end
    for (int k = hole; k >= 1; k--) begin
      if (mv[m][k-1]) begin
        md[m][k] = md[m][k-1];
        mk[m][k] = mk[m][k-1];
      end
      mv[m][k] = mv[m][k-1];
    end
    if (hole >= 0) begin
      mv[m][0] = i_valid;
      if (i_valid) begin
        md[m][0] = i_value;
        mk[m][0] = 1'b1;
      end
    end
  endfunction

  function automatic int modelCount(int m);
    int c = 0;
    for (int k = 0; k < dep(m); k++) c += int'(mv[m][k]);
    return c;
  endfunction

  function automatic bit modelReady(int m);
    return (i_ready || (modelCount(m) < dep(m))) && !sync_reset;
  endfunction

  function automatic bit modelValid(int m);
    return mv[m][dep(m)-1] && !sync_reset;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("d4_valid", {31'b0, o_valid4}, {31'b0, modelValid(0)});
    checkOutput("d4_ready", {31'b0, o_ready4}, {31'b0, modelReady(0)});
    checkOutput("d4_count", {29'b0, o_count4}, modelCount(0));
    if (mk[0][3]) checkOutput("d4_value", {24'b0, o_value4}, {24'b0, md[0][3]});
    checkOutput("d1_valid", {31'b0, o_valid1}, {31'b0, modelValid(1)});
    checkOutput("d1_ready", {31'b0, o_ready1}, {31'b0, modelReady(1)});
    checkOutput("d1_count", {31'b0, o_count1}, modelCount(1));
    if (mk[1][0]) checkOutput("d1_value", {24'b0, o_value1}, {24'b0, md[1][0]});
  endtask

  // Drive one cycle of inputs, check settled outputs, then clock both DUT and model.
  task automatic applyStimulus(input bit valid, input logic [7:0] value, input bit ready, input bit flush);
    i_valid    = valid;
    i_value    = value;
    i_ready    = ready;
    sync_reset = flush;
    #1;
    checkAll();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must react immediately.
  task automatic asyncPulse();
    i_valid    = 1'b0;
    sync_reset = 1'b0;
    async_reset = 1'b1;
    #1;
    modelReset(0);
    modelReset(1);
    checkOutput("arst_valid4", {31'b0, o_valid4}, 32'd0);
    checkOutput("arst_count4", {29'b0, o_count4}, 32'd0);
    checkOutput("arst_value4", {24'b0, o_value4}, 32'h00);
    checkOutput("arst_valid1", {31'b0, o_valid1}, 32'd0);
    if (mk[1][0]) checkOutput("arst_value1", {24'b0, o_value1}, {24'b0, md[1][0]});
    #1;
    async_reset = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = 8'h00;
        mk[m][k] = 1'b0;
      end
    async_reset = 1'b1;
    sync_reset  = 1'b0;
    i_valid     = 1'b0;
    i_value     = 8'h00;
    i_ready     = 1'b0;
    @(posedge clk);
    #1;
    modelReset(0);
    modelReset(1);
    checkAll();
    async_reset = 1'b0;

    // Stream three words back-to-back with the consumer always ready
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: five words offered to a stalled pipeline, then drain
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubble collapse under a stall
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bubble_count", {29'b0, o_count4}, 32'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush a full pipeline while a word is offered
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
    checkOutput("flush_count", {29'b0, o_count4}, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Async reset mid-stream, then confirm full latency for the next word
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
    asyncPulse();
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes and async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) asyncPulse();
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
    $finish;
  end

endmodule
